total_register_file: RTL and testbench

- 8-entry × 16-bit register file with one synchronous write port.
- A built-in sequential scanner compares all stored entries and reports their unsigned maximum and minimum.
- Valid flags that Max/Min reflect a complete scan of current contents.
- Used as a self-contained datapath block: writes come from the controller, Max/Min/Valid feed downstream logic.

---
 rtl/total_register_file_if.sv | 31 +++
 rtl/total_register_file.sv | 121 ++++++++++++
 tb/tb_total_register_file.sv | 131 +++++++++++++
 3 files changed

// File: rtl/total_register_file_if.sv
// Write port and scan-result bundle for the 8-entry register file.
// The controller side drives writes; the register file drives Max/Min/Valid.
interface total_register_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) ();
    logic              WriteEn;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] Max;
    logic [DATA_W-1:0] Min;
    logic              Valid;

    modport master (
        output WriteEn,
        output WriteReg,
        output WriteData,
        input  Max,
        input  Min,
        input  Valid
    );

    modport slave (
        input  WriteEn,
        input  WriteReg,
        input  WriteData,
        output Max,
        output Min,
        output Valid
    );
endinterface

// File: rtl/total_register_file.sv
// 8 x 16 register file with one write port and a sequential scanner that
// reports the unsigned max/min of all entries once a full scan completes.
//
// state | meaning
// IDLE  | contents changed (or reset); next idle edge seeds running max/min from reg[0]
// SCAN  | folding reg[idx] into running max/min, one entry per idle edge
// DONE  | Max/Min/Valid reflect current contents; hold until next write or reset
module total_register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    total_register_file_if.slave   bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [DATA_W-1:0] regs [DEPTH];

    state_t            state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [DATA_W-1:0] run_max, run_max_next;
    logic [DATA_W-1:0] run_min, run_min_next;
    logic [DATA_W-1:0] max_q, max_next;
    logic [DATA_W-1:0] min_q, min_next;
    logic              valid_q, valid_next;

    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] larger;
    logic [DATA_W-1:0] smaller;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.WriteEn) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    assign cur     = regs[idx];
    assign larger  = (cur > run_max) ? cur : run_max;
    assign smaller = (cur < run_min) ? cur : run_min;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            run_max <= '0;
            run_min <= '0;
            max_q   <= '0;
            min_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            run_max <= run_max_next;
            run_min <= run_min_next;
            max_q   <= max_next;
            min_q   <= min_next;
            valid_q <= valid_next;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        run_max_next = run_max;
        run_min_next = run_min;
        max_next     = max_q;
        min_next     = min_q;
        valid_next   = valid_q;

        // Any write invalidates the result and restarts from IDLE; Max/Min hold.
        if (bus.WriteEn) begin
            state_next = IDLE;
            idx_next   = '0;
            valid_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    run_max_next = regs[0];
                    run_min_next = regs[0];
                    idx_next     = ONE_IDX;
                    state_next   = SCAN;
                end
                SCAN: begin
                    run_max_next = larger;
                    run_min_next = smaller;
                    idx_next     = idx + ONE_IDX;
                    if (idx == LAST_IDX) begin
                        max_next   = larger;
                        min_next   = smaller;
                        valid_next = 1'b1;
                        state_next = DONE;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    assign bus.Max   = max_q;
    assign bus.Min   = min_q;
    assign bus.Valid = valid_q;
endmodule

// File: tb/tb_total_register_file.sv
// Directed-vector bench: the driver queues the expected Max/Min/Valid after
// each edge; a negedge monitor pops and compares against the DUT outputs.
module tb_total_register_file;
    localparam int DW = 16;
    localparam int AW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    total_register_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    total_register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic          v;
        logic [DW-1:0] mx;
        logic [DW-1:0] mn;
    } exp_t;

    exp_t exp_q[$];
    int   id_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   step_no = 0;

    task automatic chk(input string name, input int id,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   id;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            chk("valid", id, {{(DW-1){1'b0}}, bus.Valid}, {{(DW-1){1'b0}}, e.v});
            chk("max",   id, bus.Max, e.mx);
            chk("min",   id, bus.Min, e.mn);
        end
    end

    task automatic step(input logic rst, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic ev,
                        input logic [DW-1:0] emx, input logic [DW-1:0] emn);
        exp_t e;
        @(negedge clk);
        rst_n         = rst;
        bus.WriteEn   = we;
        bus.WriteReg  = a;
        bus.WriteData = d;
        @(posedge clk);
        step_no++;
        e.v  = ev;
        e.mx = emx;
        e.mn = emn;
        exp_q.push_back(e);
        id_q.push_back(step_no);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] hold_mx, input logic [DW-1:0] hold_mn);
        step(1'b1, 1'b1, a, d, 1'b0, hold_mx, hold_mn);
    endtask

    task automatic idle(input logic ev, input logic [DW-1:0] emx, input logic [DW-1:0] emn);
        step(1'b1, 1'b0, '0, '0, ev, emx, emn);
    endtask

    // Eight idle edges: outputs hold old values with Valid=0 for seven,
    // then the eighth publishes the new result; one more edge checks DONE holds.
    task automatic idle_scan(input logic [DW-1:0] old_mx, input logic [DW-1:0] old_mn,
                             input logic [DW-1:0] new_mx, input logic [DW-1:0] new_mn);
        for (int k = 1; k <= 7; k++) idle(1'b0, old_mx, old_mn);
        idle(1'b1, new_mx, new_mn);
        idle(1'b1, new_mx, new_mn);
    endtask

    initial begin
        bus.WriteEn   = 1'b0;
        bus.WriteReg  = '0;
        bus.WriteData = '0;

        // Reset, then a scan of all-zero contents.
        step(1'b0, 1'b0, '0, '0, 1'b0, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, '0, '0, 1'b0, 16'h0000, 16'h0000);
        idle_scan(16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // reg[i] = i
        for (int i = 0; i < 8; i++) wr(AW'(i), DW'(i), 16'h0000, 16'h0000);
        idle_scan(16'h0000, 16'h0000, 16'h0007, 16'h0000);

        // Single write from DONE: outputs hold 7/0 until rescan.
        wr(3'd3, 16'hFFFF, 16'h0007, 16'h0000);
        idle_scan(16'h0007, 16'h0000, 16'hFFFF, 16'h0000);

        // All equal.
        for (int i = 0; i < 8; i++) wr(AW'(i), 16'h1234, 16'hFFFF, 16'h0000);
        idle_scan(16'hFFFF, 16'h0000, 16'h1234, 16'h1234);

        // Abort a scan after 4 idle edges with a write to reg[7].
        wr(3'd0, 16'h1234, 16'h1234, 16'h1234);
        for (int k = 0; k < 4; k++) idle(1'b0, 16'h1234, 16'h1234);
        wr(3'd7, 16'h8000, 16'h1234, 16'h1234);
        idle_scan(16'h1234, 16'h1234, 16'h8000, 16'h1234);

        // Reset mid-scan with a write asserted: write ignored, all cleared.
        wr(3'd2, 16'h0005, 16'h8000, 16'h1234);
        for (int k = 0; k < 3; k++) idle(1'b0, 16'h8000, 16'h1234);
        step(1'b0, 1'b1, 3'd1, 16'hABCD, 1'b0, 16'h0000, 16'h0000);
        idle_scan(16'h0000, 16'h0000, 16'h0000, 16'h0000);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
